// File: rtl/board_b_pixel_mixer.sv
// Pixel mixer: resolves front/back/sprite priority, looks the winning pen up in a
// CPU-writable 1024x15 palette and emits registered 5:5:5 RGB with a delayed blank flag.
module board_b_pixel_mixer #(
    parameter logic [9:0] BACKDROP_IDX = 10'h200,
    parameter bit         PIPE_CE      = 1'b1
) (
    input  logic        CLK_32M,
    input  logic        reset_n,
    input  logic        CE_PIX,
    input  logic        HBLANK,
    input  logic        VBLANK,
    input  logic [3:0]  A_BIT,
    input  logic [3:0]  A_COL,
    input  logic        A_CP15,
    input  logic        A_CP8,
    input  logic [3:0]  B_BIT,
    input  logic [3:0]  B_COL,
    input  logic        B_CP15,
    input  logic        B_CP8,
    input  logic [3:0]  S_PIX,
    input  logic [3:0]  S_COL,
    input  logic [2:0]  LAYER_EN,
    input  logic [9:0]  PAL_A,
    input  logic [15:0] PAL_DIN,
    input  logic        PAL_WR,
    output logic [15:0] PAL_DOUT,
    output logic [4:0]  R,
    output logic [4:0]  G,
    output logic [4:0]  B,
    output logic        BLANK_OUT
);

    logic        adv;

    // S0 registers
    logic [3:0]  s0_a_bit_q, s0_a_col_q, s0_b_bit_q, s0_b_col_q, s0_s_pix_q, s0_s_col_q;
    logic        s0_a_cp15_q, s0_a_cp8_q, s0_b_cp15_q, s0_b_cp8_q;
    logic [2:0]  s0_en_q;
    logic        s0_blank_q, s0_valid_q;

    // S1 registers (palette read data plus control)
    logic [14:0] vid_q;
    logic        s1_blank_q, s1_valid_q;

    // Priority resolve
    logic        a_op, b_op, s_op, a_hi, b_hi;
    logic [9:0]  vid_idx;

    logic [14:0] pal_mem [1024];

    // Bit 15 of CPU write data has no storage
    logic        unused_din;
    assign unused_din = PAL_DIN[15];

    // Pipeline advance strobe
    always_comb begin
        adv = PIPE_CE ? CE_PIX : 1'b1;
    end

    // S0: capture all pixel inputs and the combined blank
    always_ff @(posedge CLK_32M) begin
        if (!reset_n) begin
            s0_a_bit_q  <= '0;
            s0_a_col_q  <= '0;
            s0_a_cp15_q <= 1'b0;
            s0_a_cp8_q  <= 1'b0;
            s0_b_bit_q  <= '0;
            s0_b_col_q  <= '0;
            s0_b_cp15_q <= 1'b0;
            s0_b_cp8_q  <= 1'b0;
            s0_s_pix_q  <= '0;
            s0_s_col_q  <= '0;
            s0_en_q     <= '0;
            s0_blank_q  <= 1'b1;
            s0_valid_q  <= 1'b0;
        end else if (adv) begin
            s0_a_bit_q  <= A_BIT;
            s0_a_col_q  <= A_COL;
            s0_a_cp15_q <= A_CP15;
            s0_a_cp8_q  <= A_CP8;
            s0_b_bit_q  <= B_BIT;
            s0_b_col_q  <= B_COL;
            s0_b_cp15_q <= B_CP15;
            s0_b_cp8_q  <= B_CP8;
            s0_s_pix_q  <= S_PIX;
            s0_s_col_q  <= S_COL;
            s0_en_q     <= LAYER_EN;
            s0_blank_q  <= HBLANK | VBLANK;
            s0_valid_q  <= 1'b1;
        end
    end

    // S1 priority: A_hi > B_hi > sprite > A > B > backdrop
    always_comb begin
        a_op = (s0_a_bit_q != 4'd0) && s0_en_q[0];
        b_op = (s0_b_bit_q != 4'd0) && s0_en_q[1];
        s_op = (s0_s_pix_q != 4'd0) && s0_en_q[2];
        a_hi = a_op && (s0_a_cp15_q || (s0_a_cp8_q && s0_a_bit_q[3]));
        b_hi = b_op && (s0_b_cp15_q || (s0_b_cp8_q && s0_b_bit_q[3]));
        if (a_hi) begin
            vid_idx = {2'b01, s0_a_col_q, s0_a_bit_q};
        end else if (b_hi) begin
            vid_idx = {2'b10, s0_b_col_q, s0_b_bit_q};
        end else if (s_op) begin
            vid_idx = {2'b00, s0_s_col_q, s0_s_pix_q};
        end else if (a_op) begin
            vid_idx = {2'b01, s0_a_col_q, s0_a_bit_q};
        end else if (b_op) begin
            vid_idx = {2'b10, s0_b_col_q, s0_b_bit_q};
        end else begin
            vid_idx = BACKDROP_IDX;
        end
    end

    // CPU palette write; contents intentionally survive reset
    always_ff @(posedge CLK_32M) begin
        if (PAL_WR) begin
            pal_mem[PAL_A] <= PAL_DIN[14:0];
        end
    end

    // CPU read port, read-before-write
    always_ff @(posedge CLK_32M) begin
        if (!reset_n) begin
            PAL_DOUT <= '0;
        end else begin
            PAL_DOUT <= {1'b0, pal_mem[PAL_A]};
        end
    end

    // S1: video palette read (old data on same-cycle CPU write) and control shift
    always_ff @(posedge CLK_32M) begin
        if (!reset_n) begin
            vid_q      <= '0;
            s1_blank_q <= 1'b1;
            s1_valid_q <= 1'b0;
        end else if (adv) begin
            vid_q      <= pal_mem[vid_idx];
            s1_blank_q <= s0_blank_q;
            s1_valid_q <= s0_valid_q;
        end
    end

    // S2: output registers, forced black while blanking or not yet filled
    always_ff @(posedge CLK_32M) begin
        if (!reset_n) begin
            R         <= '0;
            G         <= '0;
            B         <= '0;
            BLANK_OUT <= 1'b1;
        end else if (adv) begin
            if (s1_blank_q || !s1_valid_q) begin
                R         <= '0;
                G         <= '0;
                B         <= '0;
                BLANK_OUT <= 1'b1;
            end else begin
                R         <= vid_q[14:10];
                G         <= vid_q[9:5];
                B         <= vid_q[4:0];
                BLANK_OUT <= 1'b0;
            end
        end
    end

endmodule
